// File: rtl/loop_gain_sched.sv
`default_nettype none
// ============================================================================
// Module      : loop_gain_sched
// Description : Lock/gear-shift controller for the symbol-timing PI loop
//               filter. Gates TED error strobes, clears the filter on start
//               and acquisition timeout, and selects acquisition or tracking
//               shift gains from windowed |error| statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module loop_gain_sched #(
  parameter int WERR         = 18,
  parameter int SHIFT_W      = 5,
  parameter int KP_ACQ       = 5,
  parameter int KI_ACQ       = 9,
  parameter int KP_TRK       = 7,
  parameter int KI_TRK       = 12,
  parameter int WIN_LOG2     = 6,
  parameter int LOCK_THR     = 32768,
  parameter int UNLOCK_THR   = 131072,
  parameter int LOCK_WINS    = 4,
  parameter int UNLOCK_WINS  = 2,
  parameter int TIMEOUT_WINS = 64,
  parameter int CLEAR_CYC    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable_i,
  input  logic [WERR-1:0]    e_in_i,
  input  logic               e_valid_i,
  output logic               e_valid_o,
  output logic               lf_rst_n_o,
  output logic [SHIFT_W-1:0] kp_shift_o,
  output logic [SHIFT_W-1:0] ki_shift_o,
  output logic               locked_o,
  output logic [1:0]         state_o
);

  localparam int SUM_W  = WERR - 1 + WIN_LOG2;
  localparam int GOOD_W = $clog2(LOCK_WINS + 1);
  localparam int BAD_W  = $clog2(UNLOCK_WINS + 1);
  localparam int TO_W   = $clog2(TIMEOUT_WINS + 1);
  localparam int CLR_W  = $clog2(CLEAR_CYC + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_ACQ   = 2'd2;
  localparam logic [1:0] ST_TRACK = 2'd3;

  localparam logic [SUM_W-1:0]  LOCK_THR_C   = SUM_W'(LOCK_THR);
  localparam logic [SUM_W-1:0]  UNLOCK_THR_C = SUM_W'(UNLOCK_THR);
  localparam logic [GOOD_W-1:0] LOCK_WINS_C  = GOOD_W'(LOCK_WINS);
  localparam logic [BAD_W-1:0]  UNLOCK_WINS_C = BAD_W'(UNLOCK_WINS);
  localparam logic [TO_W-1:0]   TIMEOUT_C    = TO_W'(TIMEOUT_WINS);
  localparam logic [CLR_W-1:0]  CLR_LAST_C   = CLR_W'(CLEAR_CYC - 1);

  logic [1:0]          state_q, state_d;
  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]    bad_cnt_q, bad_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

  logic                lf_rst_n_q, lf_rst_n_d;
  logic [SHIFT_W-1:0]  kp_q, kp_d;
  logic [SHIFT_W-1:0]  ki_q, ki_d;
  logic                locked_q, locked_d;

  logic                accept;
  logic                win_close;
  logic [WERR-2:0]     mag;
  logic [SUM_W-1:0]    sum_full;
  logic [GOOD_W-1:0]   good_inc;
  logic [BAD_W-1:0]    bad_inc;
  logic [TO_W-1:0]     to_inc;

  // Strobes only count (and only reach the filter) while the loop is running.
  assign accept    = e_valid_i & ((state_q == ST_ACQ) | (state_q == ST_TRACK));
  assign win_close = accept & (&win_cnt_q);

  // Saturating magnitude: the most negative code maps to the largest positive.
  always_comb begin
    mag = e_in_i[WERR-2:0];
    if (e_in_i[WERR-1]) begin
      if (e_in_i[WERR-2:0] == '0) begin
        mag = '1;
      end else begin
        mag = ~e_in_i[WERR-2:0] + {{(WERR-2){1'b0}}, 1'b1};
      end
    end
  end

  // Window statistics as they would stand after including the current sample.
  always_comb begin
    sum_full = sum_q + SUM_W'(mag);
    good_inc = (sum_full < LOCK_THR_C)   ? good_cnt_q + GOOD_W'(1) : '0;
    bad_inc  = (sum_full > UNLOCK_THR_C) ? bad_cnt_q + BAD_W'(1)   : '0;
    to_inc   = to_cnt_q + TO_W'(1);
  end

  // State register and registered outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lf_rst_n_q <= 1'b0;
      kp_q       <= SHIFT_W'(KP_ACQ);
      ki_q       <= SHIFT_W'(KI_ACQ);
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lf_rst_n_q <= lf_rst_n_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      locked_q   <= locked_d;
    end
  end

  // Next-state logic; disable overrides any window-driven transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST_C) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        if (win_close) begin
          if (good_inc == LOCK_WINS_C) begin
            state_d = ST_TRACK;
          end else if (to_inc == TIMEOUT_C) begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_TRACK: begin
        if (win_close && (bad_inc == UNLOCK_WINS_C)) state_d = ST_ACQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable_i) state_d = ST_IDLE;
  end

  // Output decode from next state so outputs move on the same edge as state.
  always_comb begin
    lf_rst_n_d = (state_d == ST_ACQ) || (state_d == ST_TRACK);
    locked_d   = (state_d == ST_TRACK);
    kp_d       = (state_d == ST_TRACK) ? SHIFT_W'(KP_TRK) : SHIFT_W'(KP_ACQ);
    ki_d       = (state_d == ST_TRACK) ? SHIFT_W'(KI_TRK) : SHIFT_W'(KI_ACQ);
  end

  // Window accumulator and decision counters; any state change restarts the
  // decision counters, while the window itself runs on through ACQ<->TRACK.
  always_comb begin
    win_cnt_d  = win_cnt_q;
    sum_d      = sum_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    to_cnt_d   = to_cnt_q;
    clr_cnt_d  = '0;
    if (accept) begin
      win_cnt_d = win_cnt_q + WIN_LOG2'(1);
      sum_d     = win_close ? '0 : sum_full;
    end
    if (win_close && (state_q == ST_ACQ)) begin
      good_cnt_d = good_inc;
      to_cnt_d   = to_inc;
    end
    if (win_close && (state_q == ST_TRACK)) begin
      bad_cnt_d = bad_inc;
    end
    if (state_d != state_q) begin
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      to_cnt_d   = '0;
    end
    if ((state_d == ST_IDLE) || (state_d == ST_CLEAR)) begin
      win_cnt_d = '0;
      sum_d     = '0;
    end
    if ((state_q == ST_CLEAR) && (state_d == ST_CLEAR)) begin
      clr_cnt_d = clr_cnt_q + CLR_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clr_cnt_q  <= '0;
      win_cnt_q  <= '0;
      sum_q      <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      clr_cnt_q  <= clr_cnt_d;
      win_cnt_q  <= win_cnt_d;
      sum_q      <= sum_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign e_valid_o  = accept;
  assign lf_rst_n_o = lf_rst_n_q;
  assign kp_shift_o = kp_q;
  assign ki_shift_o = ki_q;
  assign locked_o   = locked_q;
  assign state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_loop_gain_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_loop_gain_sched
// Description : Self-checking bench for loop_gain_sched with a behavioural
//               reference model feeding a per-cycle expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loop_gain_sched;

  logic        clk;
  logic        reset_n;
  logic        enable_i;
  logic [17:0] e_in_i;
  logic        e_valid_i;
  logic        e_valid_o;
  logic        lf_rst_n_o;
  logic [4:0]  kp_shift_o;
  logic [4:0]  ki_shift_o;
  logic        locked_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_state, m_clr, m_wcnt, m_sum, m_good, m_bad, m_to;
  int m_lfr, m_kp, m_ki, m_lock;

  logic [13:0] exp_q[$];

  loop_gain_sched dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable_i   (enable_i),
    .e_in_i     (e_in_i),
    .e_valid_i  (e_valid_i),
    .e_valid_o  (e_valid_o),
    .lf_rst_n_o (lf_rst_n_o),
    .kp_shift_o (kp_shift_o),
    .ki_shift_o (ki_shift_o),
    .locked_o   (locked_o),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mag(input int e);
    if (e >= 0) return e;
    if (e == -131072) return 131071;
    return -e;
  endfunction

  function automatic logic [13:0] pack_exp();
    logic [1:0] s;
    logic [4:0] kp, ki;
    s  = m_state[1:0];
    kp = m_kp[4:0];
    ki = m_ki[4:0];
    return {s, m_lfr[0], kp, ki, m_lock[0]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_clr = 0; m_wcnt = 0; m_sum = 0;
    m_good = 0; m_bad = 0; m_to = 0;
    m_lfr = 0; m_kp = 5; m_ki = 9; m_lock = 0;
  endtask

  // Advance the model by one clock with the inputs applied this cycle.
  task automatic model_step(input bit en, input int e, input bit v);
    int ns, s, wn;
    bit acc, close;
    ns = m_state; s = m_sum; wn = m_wcnt; close = 0;
    acc = v && (m_state >= 2);
    if (acc) begin
      s  = m_sum + mag(e);
      wn = m_wcnt + 1;
      if (wn == 64) begin
        close = 1;
        wn = 0;
      end
    end
    case (m_state)
      0: if (en) ns = 1;
      1: begin
        m_clr++;
        if (m_clr == 2) ns = 2;
      end
      2: if (close) begin
        m_good = (s < 32768) ? m_good + 1 : 0;
        m_to++;
        if (m_good == 4) ns = 3;
        else if (m_to == 64) ns = 1;
      end
      default: if (close) begin
        m_bad = (s > 131072) ? m_bad + 1 : 0;
        if (m_bad == 2) ns = 2;
      end
    endcase
    if (!en) ns = 0;
    if (ns != m_state) begin
      m_good = 0; m_bad = 0; m_to = 0; m_clr = 0;
    end
    if (ns < 2) begin
      m_wcnt = 0; m_sum = 0;
    end else begin
      m_wcnt = wn;
      m_sum  = close ? 0 : s;
    end
    m_state = ns;
    m_lfr   = (ns >= 2) ? 1 : 0;
    m_kp    = (ns == 3) ? 7 : 5;
    m_ki    = (ns == 3) ? 12 : 9;
    m_lock  = (ns == 3) ? 1 : 0;
  endtask

  // One clock of stimulus: drive, check the combinational strobe, push the
  // expected post-edge outputs, then compare them after the edge.
  task automatic cyc(input bit en, input int e, input bit v);
    logic [13:0] got;
    @(negedge clk);
    reset_n   = 1'b1;
    enable_i  = en;
    e_in_i    = e[17:0];
    e_valid_i = v;
    #1;
    chk("e_valid_o", e_valid_o, (v && m_state >= 2) ? 1 : 0);
    model_step(en, e, v);
    exp_q.push_back(pack_exp());
    @(posedge clk);
    #1;
    got = {state_o, lf_rst_n_o, kp_shift_o, ki_shift_o, locked_o};
    chk("outputs", got, exp_q.pop_front());
  endtask

  task automatic run(input bit en, input int e, input bit v, input int n);
    for (int i = 0; i < n; i++) cyc(en, e, v);
  endtask

  task automatic rst_cyc();
    logic [13:0] got;
    @(negedge clk);
    reset_n   = 1'b0;
    enable_i  = 1'b0;
    e_valid_i = 1'b0;
    e_in_i    = '0;
    model_reset();
    exp_q.push_back(pack_exp());
    @(posedge clk);
    #1;
    got = {state_o, lf_rst_n_o, kp_shift_o, ki_shift_o, locked_o};
    chk("reset_outputs", got, exp_q.pop_front());
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_lfr"}, lf_rst_n_o, 0);
    chk({tag, "_lock"}, locked_o, 0);
    chk({tag, "_kp"}, kp_shift_o, 5);
    chk({tag, "_ki"}, ki_shift_o, 9);
    chk({tag, "_evo"}, e_valid_o, 0);
  endtask

  initial begin
    reset_n = 1'b0; enable_i = 1'b0; e_in_i = '0; e_valid_i = 1'b0;
    model_reset();

    // Reset and start-up sequence
    repeat (3) rst_cyc();
    chk_reset_vals("reset");
    cyc(1, 0, 0);
    chk("start_clear1", state_o, 1);
    chk("start_lfr1", lf_rst_n_o, 0);
    cyc(1, 0, 0);
    chk("start_clear2", state_o, 1);
    cyc(1, 0, 0);
    chk("start_acq", state_o, 2);
    chk("start_lfr", lf_rst_n_o, 1);
    chk("start_kp", kp_shift_o, 5);
    chk("start_ki", ki_shift_o, 9);

    // Sum exactly at LOCK_THR is not good
    run(1, 512, 1, 256);
    chk("lock_thr_edge", state_o, 2);

    // Lock on the 256th strobe of e=+100
    run(1, 100, 1, 255);
    chk("prelock", state_o, 2);
    cyc(1, 100, 1);
    chk("lock_state", state_o, 3);
    chk("lock_locked", locked_o, 1);
    chk("lock_kp", kp_shift_o, 7);
    chk("lock_ki", ki_shift_o, 12);

    // Sum exactly at UNLOCK_THR is not bad; bad then good keeps TRACK
    run(1, 2048, 1, 128);
    chk("unlock_thr_edge", state_o, 3);
    run(1, 3000, 1, 64);
    run(1, 100, 1, 64);
    chk("bad_good_track", state_o, 3);
    run(1, 3000, 1, 127);
    chk("preunlock", state_o, 3);
    cyc(1, 3000, 1);
    chk("unlock_state", state_o, 2);
    chk("unlock_locked", locked_o, 0);
    chk("unlock_lfr", lf_rst_n_o, 1);
    chk("unlock_kp", kp_shift_o, 5);
    chk("unlock_ki", ki_shift_o, 9);

    // Saturated magnitude makes a bad window: good,good,bad,good -> no lock
    run(1, 100, 1, 128);
    run(1, -131072, 1, 64);
    run(1, 100, 1, 64);
    chk("sat_nolock", state_o, 2);
    run(1, 100, 1, 191);
    chk("sat_prelock", state_o, 2);
    cyc(1, 100, 1);
    chk("sat_lock", state_o, 3);

    // Disable on the 4th good window close wins over lock
    cyc(0, 0, 0);
    chk("disable_idle", state_o, 0);
    run(1, 0, 0, 3);
    chk("restart_acq", state_o, 2);
    run(1, 100, 1, 255);
    cyc(0, 100, 1);
    chk("prio_state", state_o, 0);
    chk("prio_locked", locked_o, 0);
    chk("prio_lfr", lf_rst_n_o, 0);

    // Timeout after 64 windows, gated strobes in CLEAR, fresh ACQ after
    run(1, 0, 0, 3);
    run(1, 1000, 1, 4095);
    chk("pretimeout", state_o, 2);
    cyc(1, 1000, 1);
    chk("timeout_clear", state_o, 1);
    chk("timeout_lfr", lf_rst_n_o, 0);
    cyc(1, 1000, 1);
    chk("clear_gate", e_valid_o, 0);
    chk("timeout_clear2", state_o, 1);
    cyc(1, 1000, 1);
    chk("timeout_acq", state_o, 2);
    chk("timeout_acq_lfr", lf_rst_n_o, 1);
    run(1, 100, 1, 255);
    chk("post_to_prelock", state_o, 2);
    cyc(1, 100, 1);
    chk("post_to_lock", state_o, 3);

    // Mid-operation reset discards a partial window
    cyc(0, 0, 0);
    run(1, 0, 0, 3);
    run(1, 100, 1, 40);
    rst_cyc();
    chk_reset_vals("midreset");
    run(1, 0, 0, 3);
    run(1, 100, 1, 255);
    chk("midreset_prelock", state_o, 2);
    cyc(1, 100, 1);
    chk("midreset_lock", state_o, 3);

    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
